multicycle_ctrl: RTL and testbench

// Main FSM for the multicycle build of the CPU. It sequences one shared ALU/memory datapath through

---
 rtl/multicycle_ctrl_if.sv | 35 +++
 rtl/multicycle_ctrl.sv | 157 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - control/memory-handshake bundle between the multicycle FSM and its datapath
interface multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       op;
  logic             mem_ready;
  logic             mem_req;
  logic             i_or_d;
  logic             ir_write;
  logic             pc_write;
  logic             branch;
  logic [1:0]       pc_src;
  logic             alu_srcA;
  logic [1:0]       alu_srcB;
  logic [1:0]       alu_op;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             reg_write;
  logic             mem_write;
  logic             illegal;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instret_cnt;

  modport master (
    input  op, mem_ready,
    output mem_req, i_or_d, ir_write, pc_write, branch, pc_src, alu_srcA, alu_srcB,
           alu_op, reg_dst, mem_to_reg, reg_write, mem_write, illegal, cycle_cnt, instret_cnt
  );

  modport slave (
    output op, mem_ready,
    input  mem_req, i_or_d, ir_write, pc_write, branch, pc_src, alu_srcA, alu_srcB,
           alu_op, reg_dst, mem_to_reg, reg_write, mem_write, illegal, cycle_cnt, instret_cnt
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle CPU main FSM with memory wait states and cycle/instret counters
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  multicycle_ctrl_if.master bus
);
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXECUTE, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP
  } state_t;

  state_t           state_q, state_d;
  logic             retire;
  logic [CNT_W-1:0] cycle_q, instret_q;

  logic       mem_req, i_or_d, ir_write, pc_write, branch;
  logic [1:0] pc_src, alu_srcB, alu_op;
  logic       alu_srcA, reg_dst, mem_to_reg, reg_write, mem_write, illegal;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      cycle_q <= cycle_q + 1'b1;
      if (retire) instret_q <= instret_q + 1'b1;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    retire  = 1'b0;
    case (state_q)
      S_FETCH:   state_d = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_d = bus.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR: begin
        state_d = bus.mem_ready ? S_FETCH : S_MEMWR;
        retire  = bus.mem_ready;
      end
      S_EXECUTE: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default:   state_d = S_FETCH;
    endcase
  end

  // Reset overrides every state so no enable can fire in a reset cycle.
  always_comb begin
    mem_req    = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    pc_src     = 2'b00;
    alu_srcA   = 1'b0;
    alu_srcB   = 2'b00;
    alu_op     = 2'b00;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    illegal    = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_req  = 1'b1;
          alu_srcB = 2'b01;
          ir_write = bus.mem_ready;
          pc_write = bus.mem_ready;
        end
        S_DECODE: begin
          alu_srcB = 2'b11;
          illegal  = !(bus.op inside {OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW});
        end
        S_MEMADR, S_ADDIEX: begin
          alu_srcA = 1'b1;
          alu_srcB = 2'b10;
        end
        S_MEMRD: begin
          mem_req = 1'b1;
          i_or_d  = 1'b1;
        end
        S_MEMWB: begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
        end
        S_MEMWR: begin
          mem_req   = 1'b1;
          i_or_d    = 1'b1;
          mem_write = bus.mem_ready;
        end
        S_EXECUTE: begin
          alu_srcA = 1'b1;
          alu_op   = 2'b10;
        end
        S_ALUWB: begin
          reg_dst   = 1'b1;
          reg_write = 1'b1;
        end
        S_BRANCH: begin
          alu_srcA = 1'b1;
          alu_op   = 2'b01;
          pc_src   = 2'b01;
          branch   = 1'b1;
        end
        S_ADDIWB:  reg_write = 1'b1;
        S_JUMP: begin
          pc_src   = 2'b10;
          pc_write = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_req     = mem_req;
  assign bus.i_or_d      = i_or_d;
  assign bus.ir_write    = ir_write;
  assign bus.pc_write    = pc_write;
  assign bus.branch      = branch;
  assign bus.pc_src      = pc_src;
  assign bus.alu_srcA    = alu_srcA;
  assign bus.alu_srcB    = alu_srcB;
  assign bus.alu_op      = alu_op;
  assign bus.reg_dst     = reg_dst;
  assign bus.mem_to_reg  = mem_to_reg;
  assign bus.reg_write   = reg_write;
  assign bus.mem_write   = mem_write;
  assign bus.illegal     = illegal;
  assign bus.cycle_cnt   = cycle_q;
  assign bus.instret_cnt = instret_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  multicycle_ctrl_if #(.CNT_W(32)) ifc ();
  multicycle_ctrl_if #(.CNT_W(4))  ifc4 ();

  multicycle_ctrl #(.CNT_W(32)) dut  (.clk(clk), .reset(reset), .bus(ifc));
  multicycle_ctrl #(.CNT_W(4))  dut4 (.clk(clk), .reset(reset), .bus(ifc4));

  localparam logic [5:0] RTYPE = 6'h00, J = 6'h02, BEQ = 6'h04, ADDI = 6'h08, LW = 6'h23, SW = 6'h2b;

  // {mem_req,i_or_d,ir_write,pc_write,branch,pc_src,alu_srcA,alu_srcB,alu_op,reg_dst,mem_to_reg,reg_write,mem_write,illegal}
  function automatic logic [17:0] ctl(logic mr, logic iod, logic irw, logic pcw, logic br,
                                      logic [1:0] pcs, logic sa, logic [1:0] sb, logic [1:0] aop,
                                      logic rd, logic m2r, logic rw, logic mw, logic ill);
    return {mr, iod, irw, pcw, br, pcs, sa, sb, aop, rd, m2r, rw, mw, ill};
  endfunction

  localparam logic [17:0] C_IDLE    = 18'h0;
  localparam logic [17:0] C_FETCH_W = {1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b01,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam logic [17:0] C_FETCH_R = {1'b1,1'b0,1'b1,1'b1,1'b0,2'b00,1'b0,2'b01,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam logic [17:0] C_DECODE  = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b11,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam logic [17:0] C_DEC_ILL = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b11,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1};
  localparam logic [17:0] C_MEMADR  = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b10,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam logic [17:0] C_MEMRD   = {1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam logic [17:0] C_MEMWB   = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,1'b1,1'b1,1'b0,1'b0};
  localparam logic [17:0] C_MEMWR_W = {1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam logic [17:0] C_MEMWR_R = {1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b1,1'b0};
  localparam logic [17:0] C_EXECUTE = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b00,2'b10,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam logic [17:0] C_ALUWB   = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b1,1'b0,1'b1,1'b0,1'b0};
  localparam logic [17:0] C_BRANCH  = {1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,1'b1,2'b00,2'b01,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam logic [17:0] C_ADDIEX  = C_MEMADR;
  localparam logic [17:0] C_ADDIWB  = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,1'b0,1'b1,1'b0,1'b0};
  localparam logic [17:0] C_JUMP    = {1'b0,1'b0,1'b0,1'b1,1'b0,2'b10,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0};

  wire [17:0] obs = {ifc.mem_req, ifc.i_or_d, ifc.ir_write, ifc.pc_write, ifc.branch, ifc.pc_src,
                     ifc.alu_srcA, ifc.alu_srcB, ifc.alu_op, ifc.reg_dst, ifc.mem_to_reg,
                     ifc.reg_write, ifc.mem_write, ifc.illegal};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, check control vector at negedge, advance past posedge.
  task automatic cyc(input string tag, input logic [5:0] op, input logic rdy, input logic [17:0] exp);
    ifc.op = op;  ifc.mem_ready = rdy;
    ifc4.op = op; ifc4.mem_ready = rdy;
    @(negedge clk);
    check(tag, {14'h0, obs}, {14'h0, exp});
    @(posedge clk);
    #1;
  endtask

  initial begin
    ifc.op = RTYPE;  ifc.mem_ready = 1'b1;
    ifc4.op = RTYPE; ifc4.mem_ready = 1'b1;
    reset = 1'b1;
    repeat (3) cyc("reset_ctl", RTYPE, 1'b1, C_IDLE);
    check("reset_cycle_cnt", ifc.cycle_cnt, 32'd0);
    check("reset_instret", ifc.instret_cnt, 32'd0);
    reset = 1'b0;

    cyc("rt_fetch", RTYPE, 1'b1, C_FETCH_R);
    cyc("rt_decode", RTYPE, 1'b1, C_DECODE);
    cyc("rt_execute", RTYPE, 1'b1, C_EXECUTE);
    cyc("rt_aluwb", RTYPE, 1'b1, C_ALUWB);
    check("rt_instret", ifc.instret_cnt, 32'd1);
    check("rt_cycle_cnt", ifc.cycle_cnt, 32'd4);

    cyc("lw_fetch_w0", LW, 1'b0, C_FETCH_W);
    cyc("lw_fetch_w1", LW, 1'b0, C_FETCH_W);
    cyc("lw_fetch", LW, 1'b1, C_FETCH_R);
    cyc("lw_decode", LW, 1'b1, C_DECODE);
    cyc("lw_memadr", LW, 1'b1, C_MEMADR);
    for (int i = 0; i < 3; i++) cyc("lw_memrd_w", LW, 1'b0, C_MEMRD);
    cyc("lw_memrd", LW, 1'b1, C_MEMRD);
    cyc("lw_memwb", LW, 1'b1, C_MEMWB);
    check("lw_instret", ifc.instret_cnt, 32'd2);
    check("lw_cycle_cnt", ifc.cycle_cnt, 32'd14);

    cyc("sw_fetch", SW, 1'b1, C_FETCH_R);
    cyc("sw_decode", SW, 1'b1, C_DECODE);
    cyc("sw_memadr", SW, 1'b1, C_MEMADR);
    cyc("sw_memwr_w", SW, 1'b0, C_MEMWR_W);
    cyc("sw_memwr", SW, 1'b1, C_MEMWR_R);
    check("sw_instret", ifc.instret_cnt, 32'd3);

    cyc("addi_fetch", ADDI, 1'b1, C_FETCH_R);
    cyc("addi_decode", ADDI, 1'b1, C_DECODE);
    cyc("addi_ex", ADDI, 1'b1, C_ADDIEX);
    cyc("addi_wb", ADDI, 1'b1, C_ADDIWB);

    cyc("beq_fetch", BEQ, 1'b1, C_FETCH_R);
    cyc("beq_decode", BEQ, 1'b1, C_DECODE);
    cyc("beq_branch", BEQ, 1'b1, C_BRANCH);
    cyc("j_fetch", J, 1'b1, C_FETCH_R);
    cyc("j_decode", J, 1'b1, C_DECODE);
    cyc("j_jump", J, 1'b1, C_JUMP);
    check("beq_j_instret", ifc.instret_cnt, 32'd6);

    cyc("ill_fetch", 6'h3f, 1'b1, C_FETCH_R);
    cyc("ill_decode", 6'h3f, 1'b1, C_DEC_ILL);
    cyc("ill_next_fetch", RTYPE, 1'b0, C_FETCH_W);
    check("ill_instret", ifc.instret_cnt, 32'd6);

    // Abandon an LW in MEMRD with reset; memory reports ready in the reset cycle.
    cyc("rst_lw_fetch", LW, 1'b1, C_FETCH_R);
    cyc("rst_lw_decode", LW, 1'b1, C_DECODE);
    cyc("rst_lw_memadr", LW, 1'b1, C_MEMADR);
    cyc("rst_lw_memrd", LW, 1'b0, C_MEMRD);
    reset = 1'b1;
    cyc("rst_cycle_ctl", LW, 1'b1, C_IDLE);
    check("rst_cycle_cnt", ifc.cycle_cnt, 32'd0);
    check("rst_instret", ifc.instret_cnt, 32'd0);
    reset = 1'b0;
    cyc("rst_restart_fetch", RTYPE, 1'b0, C_FETCH_W);
    check("rst_cycle_after", ifc.cycle_cnt, 32'd1);

    for (int i = 1; i < 15; i++) cyc("wrap_fetch", RTYPE, 1'b0, C_FETCH_W);
    check("wrap_cnt15", {28'h0, ifc4.cycle_cnt}, 32'd15);
    cyc("wrap_fetch", RTYPE, 1'b0, C_FETCH_W);
    check("wrap_cnt0", {28'h0, ifc4.cycle_cnt}, 32'd0);
    check("wrap_cnt32", ifc.cycle_cnt, 32'd16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
